// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store initiator between the MEM stage and a word-wide data memory.
// One request in flight at a time. Sub-word loads are lane-extracted and
// extended; SB/SH are built by read-modify-write because the memory has no
// byte enables. Misaligned or illegal-size requests complete as faults
// without touching memory.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for a request; no memory access
//   LOAD   | memory read; selected lane captured into rsp_rdata
//   RMW_RD | memory read for SB/SH; merged word registered
//   WRITE  | single memory write (merged word or full SW data)
//   RESP   | one-cycle completion pulse, not misaligned
//   FAULT  | one-cycle completion pulse, misaligned, no memory access
//
// Memory outputs are pure decodes of state and the latched request, so
// pulling reset mid-operation removes any pending write immediately.

module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP,
    S_FAULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  lat_we;
  logic [1:0]            lat_size;
  logic                  lat_unsigned;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] merge_q;

  logic                  accept;
  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merge_word;

  assign accept    = (state == S_IDLE) && req_valid;
  assign word_addr = {lat_addr[ADDR_WIDTH-1:2], 2'b00};

  // Alignment / size check on the incoming request, evaluated at accept.
  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      SZ_BYTE: req_fault = 1'b0;
      SZ_HALF: req_fault = req_addr[0];
      SZ_WORD: req_fault = (req_addr[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    mem_valid      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    rsp_valid      = 1'b0;
    rsp_misaligned = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault) begin
            state_nxt = S_FAULT;
          end else if (!req_we) begin
            state_nxt = S_LOAD;
          end else if (req_size == SZ_WORD) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr;
        state_nxt = S_RESP;
      end
      S_RMW_RD: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = (lat_size == SZ_WORD) ? lat_wdata : merge_q;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        rsp_valid      = 1'b1;
        rsp_misaligned = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, loaded only on accept so it is stable for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end
  end

  // Lane selection and sign/zero extension of the read word.
  always_comb begin
    load_byte = mem_rdata[7:0];
    case (lat_addr[1:0])
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_size)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){load_byte[7] & ~lat_unsigned}}, load_byte};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){load_half[15] & ~lat_unsigned}}, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Read word with the target byte/half lane replaced by the store data.
  always_comb begin
    merge_word = mem_rdata;
    if (lat_size == SZ_BYTE) begin
      case (lat_addr[1:0])
        2'd0:    merge_word[7:0]   = lat_wdata[7:0];
        2'd1:    merge_word[15:8]  = lat_wdata[7:0];
        2'd2:    merge_word[23:16] = lat_wdata[7:0];
        default: merge_word[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_addr[1]) begin
      merge_word[31:16] = lat_wdata[15:0];
    end else begin
      merge_word[15:0] = lat_wdata[15:0];
    end
  end

  // Merged word holds between the RMW read and the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_q <= '0;
    end else if (state == S_RMW_RD) begin
      merge_q <= merge_word;
    end
  end

  // Response data: updated on the same edge the completion pulse starts,
  // then held until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (state == S_LOAD) begin
      rsp_rdata <= load_ext;
    end else if ((state == S_WRITE) || (accept && req_fault)) begin
      rsp_rdata <= '0;
    end
  end

endmodule
